// File: rtl/uart_tx.sv
// uart_tx: UART byte transmitter. Frames each accepted byte as one start bit
// (0), eight data bits LSB first and one stop bit (1), each bit held for
// CLKS_PER_BIT clocks.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   tx_start   - send request, honoured only while idle
//   tx_data    - byte to send, captured on the accept edge
//   serial_out - serial line, idles high (registered)
//   tx_busy    - high while a frame is on the line (registered)
//   tx_done    - one-cycle pulse in the first idle cycle after a frame (registered)
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       serial_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 3;
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [IW-1:0] bit_idx, bit_idx_next;
  logic [DW-1:0] shift_reg, shift_next;
  logic          serial_next, busy_next, done_next;
  logic          bit_end_c;

  assign bit_end_c = (timer == TIMER_MAX);

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      serial_out <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      bit_idx    <= bit_idx_next;
      shift_reg  <= shift_next;
      serial_out <= serial_next;
      tx_busy    <= busy_next;
      tx_done    <= done_next;
    end
  end

  // Next state; output values are computed one cycle ahead so the line
  // changes on the same edge as the state.
  always_comb begin
    state_next   = state;
    timer_next   = timer;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    serial_next  = serial_out;
    busy_next    = tx_busy;
    done_next    = 1'b0;

    case (state)
      IDLE: begin
        serial_next = 1'b1;
        busy_next   = 1'b0;
        if (tx_start) begin
          shift_next  = tx_data;
          timer_next  = '0;
          state_next  = START;
          serial_next = 1'b0;
          busy_next   = 1'b1;
        end
      end

      START: begin
        if (bit_end_c) begin
          timer_next   = '0;
          bit_idx_next = '0;
          state_next   = DATA;
          serial_next  = shift_reg[0];
        end else begin
          timer_next = timer + TW'(1);
        end
      end

      DATA: begin
        if (bit_end_c) begin
          timer_next   = '0;
          shift_next   = {1'b0, shift_reg[DW-1:1]};
          bit_idx_next = bit_idx + IW'(1);
          if (bit_idx == IW'(DW - 1)) begin
            state_next  = STOP;
            serial_next = 1'b1;
          end else begin
            // Next data bit is the one about to shift into position 0
            serial_next = shift_reg[1];
          end
        end else begin
          timer_next = timer + TW'(1);
        end
      end

      STOP: begin
        if (bit_end_c) begin
          timer_next  = '0;
          state_next  = IDLE;
          serial_next = 1'b1;
          busy_next   = 1'b0;
          done_next   = 1'b1;
        end else begin
          timer_next = timer + TW'(1);
        end
      end

      default: begin
        state_next  = IDLE;
        serial_next = 1'b1;
        busy_next   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with CLKS_PER_BIT=10.
// Outputs are sampled on the falling edge; sample k (k>=1) is the k-th cycle
// after an accept edge that follows sample 0.
module tb_uart_tx;

  localparam int unsigned CPB = 10;
  localparam int unsigned NS  = 256;

  logic       clk;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       serial_out;
  logic       tx_busy;
  logic       tx_done;

  int vectors = 0;
  int errors  = 0;

  logic       start_sched [NS];
  logic [7:0] data_sched  [NS];
  logic       ser_q  [NS];
  logic       busy_q [NS];
  logic       done_q [NS];

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .serial_out(serial_out),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_sched();
    for (int k = 0; k < NS; k++) begin
      start_sched[k] = 1'b0;
      data_sched[k]  = 8'h00;
    end
  endtask

  // Samples outputs at n falling edges, then applies that step's drive values.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ser_q[k]  = serial_out;
      busy_q[k] = tx_busy;
      done_q[k] = tx_done;
      tx_start  = start_sched[k];
      tx_data   = data_sched[k];
    end
    tx_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_start = 1'b0;
    tx_data = 8'h00;
    #1;
    vectors++;
    if ({serial_out, tx_busy, tx_done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_immediate: got ser/busy/done=%b required 100", {serial_out, tx_busy, tx_done});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_sched();
    run(20);
    for (int k = 0; k < 20; k++) begin
      vectors++;
      if ({ser_q[k], busy_q[k], done_q[k]} !== 3'b100) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got ser/busy/done=%b required 100", k, {ser_q[k], busy_q[k], done_q[k]});
      end
    end
  endtask

  task automatic test_frame_a5();
    logic [9:0] exp_bits;
    int busy_cnt, done_cnt;
    exp_bits = {1'b1, 8'hA5, 1'b0};
    clear_sched();
    start_sched[0] = 1'b1;
    data_sched[0]  = 8'hA5;
    run(120);
    for (int b = 0; b < 10; b++) begin
      for (int s = 1; s <= 10; s++) begin
        vectors++;
        if (ser_q[10*b + s] !== exp_bits[b]) begin
          errors++;
          $display("FAIL a5_bit%0d sample %0d: got %b required %b", b, 10*b + s, ser_q[10*b + s], exp_bits[b]);
        end
      end
    end
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 120; k++) begin
      if (busy_q[k] === 1'b1) busy_cnt++;
      if (done_q[k] === 1'b1) done_cnt++;
    end
    vectors++;
    if (busy_cnt != 100) begin
      errors++;
      $display("FAIL a5_busy_cycles: got %0d required 100", busy_cnt);
    end
    vectors++;
    if (done_cnt != 1 || done_q[101] !== 1'b1) begin
      errors++;
      $display("FAIL a5_done: got count %0d done[101]=%b required 1 and 1", done_cnt, done_q[101]);
    end
    vectors++;
    if (busy_q[1] !== 1'b1 || busy_q[100] !== 1'b1 || busy_q[101] !== 1'b0 || busy_q[0] !== 1'b0) begin
      errors++;
      $display("FAIL a5_busy_edges: got b0=%b b1=%b b100=%b b101=%b required 0110",
               busy_q[0], busy_q[1], busy_q[100], busy_q[101]);
    end
  endtask

  task automatic test_ignore_busy_start();
    logic [9:0] exp_bits;
    int done_cnt;
    exp_bits = {1'b1, 8'hA5, 1'b0};
    clear_sched();
    start_sched[0]  = 1'b1;
    data_sched[0]   = 8'hA5;
    start_sched[43] = 1'b1;
    data_sched[43]  = 8'hFF;
    run(140);
    for (int b = 0; b < 10; b++) begin
      vectors++;
      if (ser_q[10*b + 5] !== exp_bits[b] || ser_q[10*b + 10] !== exp_bits[b]) begin
        errors++;
        $display("FAIL ignore_bit%0d: got %b/%b required %b", b, ser_q[10*b + 5], ser_q[10*b + 10], exp_bits[b]);
      end
    end
    done_cnt = 0;
    for (int k = 0; k < 140; k++) if (done_q[k] === 1'b1) done_cnt++;
    vectors++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d required 1", done_cnt);
    end
    for (int k = 102; k < 140; k++) begin
      vectors++;
      if (ser_q[k] !== 1'b1 || busy_q[k] !== 1'b0) begin
        errors++;
        $display("FAIL ignore_no_second_frame[%0d]: got ser=%b busy=%b required 1 0", k, ser_q[k], busy_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp1, exp2;
    int done_cnt;
    exp1 = {1'b1, 8'h00, 1'b0};
    exp2 = {1'b1, 8'h3C, 1'b0};
    clear_sched();
    for (int k = 0; k <= 201; k++) begin
      start_sched[k] = 1'b1;
      data_sched[k]  = (k <= 100) ? 8'h00 : 8'h3C;
    end
    run(215);
    for (int b = 0; b < 10; b++) begin
      vectors++;
      if (ser_q[10*b + 1] !== exp1[b] || ser_q[10*b + 10] !== exp1[b]) begin
        errors++;
        $display("FAIL b2b_f1_bit%0d: got %b/%b required %b", b, ser_q[10*b + 1], ser_q[10*b + 10], exp1[b]);
      end
      vectors++;
      if (ser_q[102 + 10*b] !== exp2[b] || ser_q[111 + 10*b] !== exp2[b]) begin
        errors++;
        $display("FAIL b2b_f2_bit%0d: got %b/%b required %b", b, ser_q[102 + 10*b], ser_q[111 + 10*b], exp2[b]);
      end
    end
    vectors++;
    if ({ser_q[101], busy_q[101], done_q[101]} !== 3'b101) begin
      errors++;
      $display("FAIL b2b_gap: got ser/busy/done=%b required 101", {ser_q[101], busy_q[101], done_q[101]});
    end
    done_cnt = 0;
    for (int k = 0; k < 215; k++) if (done_q[k] === 1'b1) done_cnt++;
    vectors++;
    if (done_cnt != 2 || done_q[202] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: got count %0d done[202]=%b required 2 and 1", done_cnt, done_q[202]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] exp_bits;
    int done_cnt;
    clear_sched();
    start_sched[0] = 1'b1;
    data_sched[0]  = 8'h0F;
    run(56);
    vectors++;
    if (ser_q[55] !== 1'b0 || busy_q[55] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: got ser=%b busy=%b required 0 1", ser_q[55], busy_q[55]);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({serial_out, tx_busy, tx_done} !== 3'b100) begin
      errors++;
      $display("FAIL midrst_async: got ser/busy/done=%b required 100", {serial_out, tx_busy, tx_done});
    end
    @(negedge clk);
    rst = 1'b0;
    clear_sched();
    run(30);
    done_cnt = 0;
    for (int k = 0; k < 30; k++) if (done_q[k] === 1'b1 || busy_q[k] !== 1'b0 || ser_q[k] !== 1'b1) done_cnt++;
    vectors++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL midrst_quiet: got %0d bad idle samples required 0", done_cnt);
    end
    exp_bits = {1'b1, 8'h81, 1'b0};
    clear_sched();
    start_sched[0] = 1'b1;
    data_sched[0]  = 8'h81;
    run(110);
    for (int b = 0; b < 10; b++) begin
      vectors++;
      if (ser_q[10*b + 1] !== exp_bits[b] || ser_q[10*b + 10] !== exp_bits[b]) begin
        errors++;
        $display("FAIL midrst_81_bit%0d: got %b/%b required %b", b, ser_q[10*b + 1], ser_q[10*b + 10], exp_bits[b]);
      end
    end
    vectors++;
    if (done_q[101] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_81_done: got %b required 1", done_q[101]);
    end
  endtask

  task automatic test_data_change();
    logic [9:0] exp_bits;
    exp_bits = {1'b1, 8'hC3, 1'b0};
    clear_sched();
    start_sched[0] = 1'b1;
    data_sched[0]  = 8'hC3;
    data_sched[1]  = 8'h00;
    run(110);
    for (int b = 0; b < 10; b++) begin
      vectors++;
      if (ser_q[10*b + 5] !== exp_bits[b]) begin
        errors++;
        $display("FAIL c3_bit%0d: got %b required %b", b, ser_q[10*b + 5], exp_bits[b]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_ignore_busy_start();
    test_back_to_back();
    test_reset_mid_frame();
    test_data_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
